// File: rtl/ula_md_pkg.sv
// ula_md_pkg: shared constants for the iterative multiply/divide unit.
//   - OP encodings for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   - FSM state encoding (IDLE, BUSY, FINISH)
//   - dz_lo_value(): LO result written by a divide with a zero divisor
package ula_md_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Widest operand the LO constant helper can produce.
  localparam int MD_MAX_W = 128;

  // All ones in the low w bits; callers slice to their own width.
  function automatic logic [MD_MAX_W-1:0] dz_lo_value(input int unsigned w);
    logic [MD_MAX_W-1:0] ones;
    ones = '1;
    return ones >> (MD_MAX_W - w);
  endfunction

endpackage

// File: rtl/ula_md_core.sv
// ula_md_core: one iteration of the multiply/divide datapath (combinational).
//   is_div  : 0 = shift-add multiply, 1 = restoring divide
//   step_en : when low, prod_d/rem_d simply follow prod_q/rem_q
//   prod_q  : multiply -> {partial high, remaining multiplier bits}
//             divide   -> low half shifts dividend out and quotient in
//   rem_q   : divide partial remainder (WIDTH+1 bits)
//   opb     : multiplicand magnitude (multiply) or divisor magnitude (divide)
module ula_md_core #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic                 step_en,
  input  logic [2*WIDTH-1:0]   prod_q,
  input  logic [WIDTH:0]       rem_q,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   prod_d,
  output logic [WIDTH:0]       rem_d
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb} : '0);
    div_shift = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    // No borrow out of the trial subtraction means the divisor fits.
    div_ge    = ~div_diff[WIDTH+1];

    prod_d = prod_q;
    rem_d  = rem_q;
    if (step_en) begin
      if (is_div) begin
        rem_d  = div_ge ? div_diff[WIDTH:0] : div_shift;
        prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], div_ge};
      end else begin
        // Carry of the add lands in the top bit as the product shifts right.
        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ula_mult_div.sv
// ula_mult_div: iterative MIPS multiply/divide unit with HI/LO registers.
//   clock, reset_n        : clock, async active-low reset
//   in_valid / in_ready   : request handshake (accept = in_valid & in_ready & ~cancel)
//   OP, In1, In2          : operation and rs/rt operands
//   cancel                : abort an operation in BUSY/FINISH
//   done                  : one-cycle pulse after HI/LO update
//   div_zero              : sticky, last completed DIV/DIVU had a zero divisor
//   Hi, Lo                : result registers
//
// state  | meaning
// IDLE   | ready for a request; MTHI/MTLO complete here directly
// BUSY   | WIDTH shift-add / restoring-divide iterations
// FINISH | sign fix-up and HI/LO write
module ula_mult_div
  import ula_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             cancel,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [MD_MAX_W-1:0] DZ_LO_ALL = dz_lo_value(WIDTH);
  localparam logic [WIDTH-1:0]    DZ_LO     = DZ_LO_ALL[WIDTH-1:0];

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               accept;
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] core_prod;
  logic [WIDTH:0]     core_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid & in_ready & ~cancel;
  assign op_signed = ~OP[0];
  assign a_neg     = op_signed & In1[WIDTH-1];
  assign b_neg     = op_signed & In2[WIDTH-1];
  assign a_mag     = a_neg ? (~In1 + 1'b1) : In1;
  assign b_mag     = b_neg ? (~In2 + 1'b1) : In2;

  ula_md_core #(.WIDTH(WIDTH)) u_core (
    .is_div  (is_div_q),
    .step_en (state_q == ST_BUSY),
    .prod_q  (prod_q),
    .rem_q   (rem_q),
    .opb     (opb_q),
    .prod_d  (core_prod),
    .rem_d   (core_rem)
  );

  // Sign fix-up on magnitudes. A zero divisor still runs the iterations,
  // which leave |In1| in the remainder, so negating restores In1 exactly.
  assign prod_fix = res_neg_q ? (~prod_q + 1'b1) : prod_q;
  assign quot_fix = dz_q ? DZ_LO
                         : (res_neg_q ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0]);
  assign rem_fix  = rem_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (OP)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = ST_BUSY;
              cnt_d     = '0;
              is_div_d  = OP[1];
              res_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              dz_d      = OP[1] & (In2 == '0);
              rem_d     = '0;
              if (OP[1]) begin
                prod_d = {{WIDTH{1'b0}}, a_mag};
                opb_d  = b_mag;
              end else begin
                prod_d = {{WIDTH{1'b0}}, b_mag};
                opb_d  = a_mag;
              end
            end
            OP_MTHI: begin
              hi_d   = In1;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = In1;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          prod_d = core_prod;
          rem_d  = core_rem;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d       = rem_fix;
            lo_d       = quot_fix;
            div_zero_d = dz_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      prod_q     <= '0;
      rem_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_ula_mult_div.sv
module tb_ula_mult_div;

  localparam int WIDTH = 32;
  localparam int LAT_MD = WIDTH + 2;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  OP;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        cancel;
  logic        done;
  logic        div_zero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;

  // Reference architectural state.
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  ula_mult_div #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .OP       (OP),
    .In1      (In1),
    .In2      (In2),
    .cancel   (cancel),
    .done     (done),
    .div_zero (div_zero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plain-arithmetic model of the MIPS HI/LO semantics.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     bits;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin bits = sa * sb; m_hi = bits[63:32]; m_lo = bits[31:0]; end
      3'd1: begin bits = ua * ub; m_hi = bits[63:32]; m_lo = bits[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1;
        end else begin
          if (op == 3'd2) begin
            sq = sa / sb; sr = sa % sb;
            bits = sq; m_lo = bits[31:0];
            bits = sr; m_hi = bits[31:0];
          end else begin
            bits = ua / ub; m_lo = bits[31:0];
            bits = ua % ub; m_hi = bits[31:0];
          end
          m_dz = 1'b0;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Drives one request from a falling edge and follows it to done.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int ready_bad,
                       output logic ready_at_done, output logic done_after);
    lat = -1; ready_bad = 0; ready_at_done = 1'b0; done_after = 1'b1;
    OP = op; In1 = a; In2 = b; in_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= WIDTH + 8; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (done) begin
        lat = c; ready_at_done = in_ready;
        break;
      end
      if (in_ready) ready_bad++;
    end
    @(negedge clock);
    done_after = done;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; cancel = 1'b0; OP = 3'd0; In1 = '0; In2 = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", Lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd1, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [31:0] t_a  [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'h12345678,
                               32'd3, 32'd9, 32'h80000000, 32'hFFFFFFF8, 32'd7, 32'h80000000};
    logic [31:0] t_b  [11] = '{32'd5, 32'hFFFFFFFF, 32'd7, 32'd2, 32'd0,
                               32'd4, 32'd3, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 32'd0};
    logic [31:0] t_hi [11] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'h12345678,
                               32'd0, 32'd0, 32'd0, 32'hFFFFFFF8, 32'd1, 32'h80000000};
    logic [31:0] t_lo [11] = '{32'hFFFFFFF1, 32'h00000001, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'd12, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
    logic        t_dz [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat, rb;
    logic rad, da;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], lat, rb, rad, da);
      model_op(t_op[i], t_a[i], t_b[i]);
      checks++; if (lat != LAT_MD) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT_MD); end
      checks++; if (rb != 0) begin errors++; $display("FAIL dir%0d_busy_ready: in_ready high %0d busy cycles, expected 0", i, rb); end
      checks++; if (rad !== 1'b1) begin errors++; $display("FAIL dir%0d_ready_at_done: got %b expected 1", i, rad); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: done after pulse %b expected 0", i, da); end
      checks++; if (Hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h expected %h", i, Hi, t_hi[i]); end
      checks++; if (Lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h expected %h", i, Lo, t_lo[i]); end
      checks++; if (div_zero !== t_dz[i]) begin errors++; $display("FAIL dir%0d_div_zero: got %b expected %b", i, div_zero, t_dz[i]); end
    end
  endtask

  task automatic test_back_to_back_mt;
    OP = 3'd4; In1 = 32'hCAFE0000; In2 = '0; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    m_hi = 32'hCAFE0000;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mthi_done: got %b expected 1", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mthi_ready: got %b expected 1", in_ready); end
    OP = 3'd5; In1 = 32'h0000BEEF;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    m_lo = 32'h0000BEEF;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mtlo_done: got %b expected 1", done); end
    checks++; if (Hi !== m_hi) begin errors++; $display("FAIL mt_hi: got %h expected %h", Hi, m_hi); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mt_done_drop: got %b expected 0", done); end
    checks++; if (Lo !== m_lo) begin errors++; $display("FAIL mt_lo: got %h expected %h", Lo, m_lo); end
  endtask

  // Cancel a request at cycle cyc (counted from accept) and confirm nothing is written.
  task automatic test_cancel_at(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int cyc, input string name);
    int dcount;
    dcount = 0;
    OP = op; In1 = a; In2 = b; in_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= cyc; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (done) dcount++;
    end
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", name, in_ready); end
    for (int c = 0; c < WIDTH + 6; c++) begin
      if (done) dcount++;
      @(negedge clock);
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL %s_no_done: got %0d pulses expected 0", name, dcount); end
    checks++; if (Hi !== m_hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", name, Hi, m_hi); end
    checks++; if (Lo !== m_lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", name, Lo, m_lo); end
    checks++; if (div_zero !== m_dz) begin errors++; $display("FAIL %s_div_zero: got %b expected %b", name, div_zero, m_dz); end
  endtask

  task automatic test_cancel;
    test_cancel_at(3'd0, 32'h00001234, 32'h00005678, 10, "cancel_busy");
    // FINISH is the cycle after the last iteration.
    test_cancel_at(3'd2, 32'h00000055, 32'd0, WIDTH + 1, "cancel_finish");
    // cancel in IDLE blocks an accept in the same cycle.
    OP = 3'd4; In1 = 32'h11111111; in_valid = 1'b1; cancel = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; cancel = 1'b0;
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_idle_done: got %b expected 0", done); end
    checks++; if (Hi !== m_hi) begin errors++; $display("FAIL cancel_idle_hi: got %h expected %h", Hi, m_hi); end
  endtask

  task automatic test_illegal;
    int dcount, nrdy;
    dcount = 0; nrdy = 0;
    OP = 3'd6; In1 = 32'hDEADBEEF; In2 = 32'd3; in_valid = 1'b1;
    @(negedge clock);
    OP = 3'd7;
    @(negedge clock);
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) dcount++;
      if (!in_ready) nrdy++;
      @(negedge clock);
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL illegal_done: got %0d pulses expected 0", dcount); end
    checks++; if (nrdy != 0) begin errors++; $display("FAIL illegal_ready: not ready %0d cycles expected 0", nrdy); end
    checks++; if (Hi !== m_hi || Lo !== m_lo) begin errors++; $display("FAIL illegal_hilo: got %h/%h expected %h/%h", Hi, Lo, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid;
    int lat, rb;
    logic rad, da;
    issue(3'd3, 32'd77, 32'd0, lat, rb, rad, da);
    model_op(3'd3, 32'd77, 32'd0);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL rstmid_pre_dz: got %b expected 1", div_zero); end
    OP = 3'd2; In1 = 32'd100; In2 = 32'd3; in_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo: got %h/%h expected 0/0", Hi, Lo); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL rstmid_dz: got %b expected 0", div_zero); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    issue(3'd3, 32'd50, 32'd5, lat, rb, rad, da);
    model_op(3'd3, 32'd50, 32'd5);
    checks++; if (lat != LAT_MD) begin errors++; $display("FAIL rstmid_after_lat: got %0d expected %0d", lat, LAT_MD); end
    checks++; if (Lo !== 32'd10 || Hi !== 32'd0) begin errors++; $display("FAIL rstmid_after_res: got %h/%h expected 0/a", Hi, Lo); end
  endtask

  task automatic test_random;
    int lat, rb, exp_lat;
    logic rad, da;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      exp_lat = (op >= 3'd4) ? 1 : LAT_MD;
      issue(op, a, b, lat, rb, rad, da);
      model_op(op, a, b);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: op %0d got %0d expected %0d", i, op, lat, exp_lat); end
      checks++; if (rb != 0 || rad !== 1'b1 || da !== 1'b0) begin errors++; $display("FAIL rnd%0d_handshake: busy_ready %0d ready_at_done %b done_after %b expected 0/1/0", i, rb, rad, da); end
      checks++; if (Hi !== m_hi) begin errors++; $display("FAIL rnd%0d_hi: op %0d a %h b %h got %h expected %h", i, op, a, b, Hi, m_hi); end
      checks++; if (Lo !== m_lo) begin errors++; $display("FAIL rnd%0d_lo: op %0d a %h b %h got %h expected %h", i, op, a, b, Lo, m_lo); end
      checks++; if (div_zero !== m_dz) begin errors++; $display("FAIL rnd%0d_div_zero: got %b expected %b", i, div_zero, m_dz); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back_mt;
    test_cancel;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_mult_div.md
Name: ula_mult_div

Overview:
Parametrised iterative multiply/divide unit that runs beside the combinational ULA. It executes MIPS MULT, MULTU, DIV and DIVU over many cycles, one bit per cycle, and holds the results in HI/LO registers. It also executes MTHI and MTLO. The datapath reads HI/LO directly for MFHI/MFLO. A valid/ready handshake lets the pipeline stall while the unit is busy.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits; minimum 4.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; not overridden).

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  request present.
in_ready  out  1  unit can accept a request this cycle.
OP  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 illegal.
In1  in  WIDTH  rs: multiplicand, dividend, or MTHI/MTLO source.
In2  in  WIDTH  rt: multiplier or divisor.
cancel  in  1  abort the operation in flight.
done  out  1  one-cycle pulse: HI/LO updated.
div_zero  out  1  sticky flag, last DIV/DIVU had divisor 0.
Hi  out  WIDTH  HI register.
Lo  out  WIDTH  LO register.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE.
  - Hi=0, Lo=0, done=0, div_zero=0, in_ready=1.
  - Counter and working registers cleared.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0; runs WIDTH iterations.
  - FINISH: in_ready=0; one cycle of sign fix-up and HI/LO write.
  - Transitions: IDLE→BUSY on accept of OP 000–011. BUSY→FINISH when counter==WIDTH-1. FINISH→IDLE.
- Accept: in_valid & in_ready at a rising edge (edge E0).
  - Operands are captured. Signed ops store magnitudes plus a result-sign bit (and remainder-sign bit for DIV).
- Iterations:
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring division; remainder is WIDTH+1 bits wide.
  - Edges E1..E_WIDTH each perform one iteration.
- Latency:
  - Edge E_(WIDTH+1) writes Hi/Lo.
  - done=1 during the cycle that follows, which coincides with IDLE and in_ready=1.
  - Total latency is WIDTH+2 cycles from accept to done visible. A new request may be accepted in the cycle done is high.
- Result mapping:
  - MULT/MULTU: {Hi,Lo} = full 2*WIDTH product, two's complement for MULT.
  - DIV/DIVU: Lo = quotient, Hi = remainder. DIV truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero (In2==0, DIV or DIVU):
  - Still takes the full latency.
  - Lo = all ones, Hi = In1 unmodified.
  - div_zero is set at the write edge.
- div_zero lifetime: cleared at the write edge of any subsequent DIV/DIVU with a nonzero divisor. Multiplies and MT* leave it unchanged.
- Signed overflow: DIV of -2^(WIDTH-1) by -1 gives Lo = -2^(WIDTH-1), Hi = 0. No flag.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - Hi (or Lo) = In1 at the accept edge.
  - done=1 the next cycle; the state stays IDLE.
- Illegal OP: accepted and ignored. No done, no state change.
- cancel:
  - In BUSY or FINISH: returns to IDLE at the next edge. Hi/Lo/div_zero are unchanged and done stays 0.
  - In IDLE: no effect. cancel has priority over an accept in the same cycle.
- in_valid while busy: ignored. The requester holds the request until in_ready.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.
- done is never asserted for two consecutive cycles from a single request.

Decomposition:
- Package ula_md_pkg: the OP encodings as localparams, the state encoding (IDLE, BUSY, FINISH), and the divide-by-zero LO constant function.
- One sub-module, ula_md_core: the per-iteration datapath. It takes mode, product/remainder regs and a step enable, and returns the next regs. It is purely combinational.
- The top module holds the FSM, counter, handshake, sign fix-up and HI/LO.

Test Plan:
- WIDTH=32, MULT In1=0xFFFFFFFD (-3), In2=5 → done at cycle 34 after accept; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; in_ready=0 for cycles 1–33.
- MULTU In1=0xFFFFFFFF, In2=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- DIVU 100/7 → Lo=14, Hi=2, div_zero=0. DIV -7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 0x12345678/0 → Lo=0xFFFFFFFF, Hi=0x12345678, div_zero=1. A following DIVU 9/3 → Lo=3, Hi=0, div_zero=0.
- MTHI 0xCAFE0000 then MTLO 0x0000BEEF back-to-back → done on two consecutive cycles; Hi/Lo hold those values. Then a MULT with cancel at cycle 10 → in_ready=1 at cycle 11, no done, Hi/Lo unchanged.
- Start DIV, assert reset_n=0 at cycle 5 → Hi=Lo=0, in_ready=1 immediately. After release, a request is accepted normally.
